ifu_fetch: RTL and testbench

- Multi-cycle instruction fetch unit sitting directly upstream of the decoder.
- Holds the PC, issues one instruction-read request at a time to a latency-variable instruction memory over a valid/ready request and valid response interface.
- Buffers the returned instruction and presents it, with its PC, to decode via a valid/ready handshake.
- Accepts a redirect (jump/branch target) from execute that flushes any in-flight fetch.

---
 rtl/ifu_fetch.sv | 121 ++++++++++++
 tb/tb_ifu_fetch.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit feeding decode.
// Optional IFU_MISALIGN_CHECK_EN: misaligned PCs fault instead of fetching.
module ifu_fetch #(
   parameter int ADDR_WIDTH = 64,
   parameter int INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(64'h8000_0000)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  resp_valid,
   input  logic [INST_WIDTH-1:0] resp_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  out_fault,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } stateT;

   stateT                 state;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  drop;
   logic [INST_WIDTH-1:0] instBuf;
   logic                  misalign;

`ifdef IFU_MISALIGN_CHECK_EN
   logic                  faultBuf;

   assign misalign  = (pc[1:0] != 2'b00);
   assign out_fault = faultBuf & (state == S_HOLD);
`else
   assign misalign  = 1'b0;
   assign out_fault = 1'b0;
`endif

   assign req_valid = (state == S_REQ) & ~misalign;
   assign req_addr  = pc;
   assign out_valid = (state == S_HOLD) & ~redirect_valid;
   assign out_inst  = instBuf;
   assign out_pc    = pc;

   // Fetch sequencer: PC, in-flight drop flag and instruction buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         drop    <= 1'b0;
         instBuf <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
         faultBuf <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               state <= S_REQ;
               if (redirect_valid) pc <= redirect_pc;
            end
            S_REQ: begin
               if (misalign) begin
                  // No memory access for a misaligned PC; report it instead.
                  if (redirect_valid) begin
                     pc <= redirect_pc;
                  end else begin
                     instBuf <= '0;
                     state   <= S_HOLD;
`ifdef IFU_MISALIGN_CHECK_EN
                     faultBuf <= 1'b1;
`endif
                  end
               end else begin
                  if (redirect_valid) pc <= redirect_pc;
                  // Accepted with the old PC; its reply must be thrown away.
                  if (req_ready) begin
                     state <= S_WAIT;
                     drop  <= redirect_valid;
                  end
               end
            end
            S_WAIT: begin
               if (resp_valid) begin
                  if (drop | redirect_valid) begin
                     drop  <= 1'b0;
                     state <= S_REQ;
                  end else begin
                     instBuf <= resp_data;
                     state   <= S_HOLD;
                  end
               end else if (redirect_valid) begin
                  drop <= 1'b1;
               end
               if (redirect_valid) pc <= redirect_pc;
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= S_REQ;
               end else if (out_ready) begin
                  pc    <= pc + ADDR_WIDTH'(4);
                  state <= S_REQ;
               end
`ifdef IFU_MISALIGN_CHECK_EN
               if (redirect_valid | out_ready) faultBuf <= 1'b0;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch unit.
module tb_ifu_fetch;

   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_pc;
   logic        out_fault;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int total  = 0;
   int passed = 0;

   ifu_fetch dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .resp_valid(resp_valid),
      .resp_data(resp_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_inst(out_inst),
      .out_pc(out_pc),
      .out_fault(out_fault),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of instruction memory as a function of address.
   function automatic logic [31:0] memFn(input logic [63:0] a);
      return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h0000_0413;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zeroIn();
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_data      = '0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
   endtask

   task automatic doReset();
      zeroIn();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // From S_REQ (aligned pc): accept, reply with data, land in S_HOLD.
   task automatic fetchOne(input logic [31:0] data);
      req_ready = 1'b1;
      tick();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_data  = data;
      tick();
      resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      zeroIn();
      rst = 1'b1;
      tick();
      total++;
      if (req_valid !== 1'b0) $display("FAIL rst_req_valid got %0b want 0", req_valid);
      else passed++;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid);
      else passed++;
      total++;
      if (out_inst !== 32'h0) $display("FAIL rst_out_inst got %h want 0", out_inst);
      else passed++;
      total++;
      if (out_fault !== 1'b0) $display("FAIL rst_out_fault got %0b want 0", out_fault);
      else passed++;
      total++;
      if (req_addr !== RST_PC) $display("FAIL rst_req_addr got %h want %h", req_addr, RST_PC);
      else passed++;
      total++;
      if (out_pc !== RST_PC) $display("FAIL rst_out_pc got %h want %h", out_pc, RST_PC);
      else passed++;
      rst = 1'b0;
      tick();
      total++;
      if (req_valid !== 1'b1) $display("FAIL rst_first_req got %0b want 1", req_valid);
      else passed++;
      // Reset while a request is outstanding, then a late reply.
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if (req_addr !== RST_PC) $display("FAIL rst_mid_addr got %h want %h", req_addr, RST_PC);
      else passed++;
      tick();
      rst        = 1'b0;
      resp_valid = 1'b1;
      resp_data  = 32'h1111_1111;
      tick();
      resp_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rst_late_resp got out_valid %0b want 0", out_valid);
      else passed++;
      total++;
      if (req_valid !== 1'b1) $display("FAIL rst_late_req got %0b want 1", req_valid);
      else passed++;
   endtask

   task automatic test_basic();
      doReset();
      tick();
      req_ready = 1'b1;
      #1;
      total++;
      if (req_valid !== 1'b1 || req_addr !== RST_PC)
         $display("FAIL basic_req got %0b/%h want 1/%h", req_valid, req_addr, RST_PC);
      else passed++;
      tick();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_data  = 32'h0000_0413;
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL basic_wait_ov got %0b want 0", out_valid);
      else passed++;
      tick();
      resp_valid = 1'b0;
      out_ready  = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b1 || out_pc !== RST_PC || out_inst !== 32'h0000_0413)
         $display("FAIL basic_out got %0b/%h/%h want 1/%h/00000413",
                  out_valid, out_pc, out_inst, RST_PC);
      else passed++;
      tick();
      out_ready = 1'b0;
      #1;
      total++;
      if (req_valid !== 1'b1 || req_addr !== RST_PC + 64'd4)
         $display("FAIL basic_next got %0b/%h want 1/%h", req_valid, req_addr, RST_PC + 64'd4);
      else passed++;
   endtask

   task automatic test_req_stall();
      doReset();
      tick();
      for (int i = 0; i < 4; i++) begin
         req_ready  = 1'b0;
         resp_valid = 1'b1;
         resp_data  = 32'hBAD0_0000 + 32'(i);
         #1;
         total++;
         if (req_valid !== 1'b1 || req_addr !== RST_PC)
            $display("FAIL stall_req got %0b/%h want 1/%h", req_valid, req_addr, RST_PC);
         else passed++;
         tick();
      end
      resp_valid = 1'b0;
      req_ready  = 1'b1;
      tick();
      req_ready = 1'b0;
      #1;
      total++;
      if (req_valid !== 1'b0) $display("FAIL stall_wait got req_valid %0b want 0", req_valid);
      else passed++;
      resp_valid = 1'b1;
      resp_data  = 32'h1234_5678;
      tick();
      resp_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || out_inst !== 32'h1234_5678)
         $display("FAIL stall_out got %0b/%h want 1/12345678", out_valid, out_inst);
      else passed++;
   endtask

   task automatic test_hold_stall();
      doReset();
      tick();
      fetchOne(32'hCAFE_0001);
      for (int i = 0; i < 5; i++) begin
         out_ready = 1'b0;
         #1;
         total++;
         if (out_valid !== 1'b1 || out_inst !== 32'hCAFE_0001 ||
             out_pc !== RST_PC || req_valid !== 1'b0)
            $display("FAIL hold_stable got %0b/%h/%h/%0b want 1/cafe0001/%h/0",
                     out_valid, out_inst, out_pc, req_valid, RST_PC);
         else passed++;
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      total++;
      if (req_valid !== 1'b1 || req_addr !== RST_PC + 64'd4)
         $display("FAIL hold_next got %0b/%h want 1/%h", req_valid, req_addr, RST_PC + 64'd4);
      else passed++;
   endtask

   task automatic test_redirect_wait();
      doReset();
      tick();
      req_ready = 1'b1;
      tick();
      req_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0300;
      tick();
      redirect_pc = 64'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      resp_valid     = 1'b1;
      resp_data      = 32'hDEAD_BEEF;
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rdw_ov_resp got %0b want 0", out_valid);
      else passed++;
      tick();
      resp_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rdw_ov_after got %0b want 0", out_valid);
      else passed++;
      total++;
      if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100)
         $display("FAIL rdw_req got %0b/%h want 1/0000000080000100", req_valid, req_addr);
      else passed++;
   endtask

   task automatic test_redirect_hold();
      doReset();
      tick();
      fetchOne(32'h0000_0013);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0200;
      out_ready      = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rdh_ov got %0b want 0", out_valid);
      else passed++;
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      #1;
      total++;
      if (req_valid !== 1'b1 || req_addr !== 64'h8000_0200)
         $display("FAIL rdh_req got %0b/%h want 1/0000000080000200", req_valid, req_addr);
      else passed++;
   endtask

   task automatic test_misalign();
      doReset();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0002;
      tick();
      redirect_valid = 1'b0;
      #1;
`ifdef IFU_MISALIGN_CHECK_EN
      total++;
      if (req_valid !== 1'b0) $display("FAIL mis_req got %0b want 0", req_valid);
      else passed++;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_fault !== 1'b1 ||
          out_inst !== 32'h0 || out_pc !== 64'h8000_0002)
         $display("FAIL mis_hold got %0b/%0b/%h/%h want 1/1/0/0000000080000002",
                  out_valid, out_fault, out_inst, out_pc);
      else passed++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      total++;
      if (out_fault !== 1'b0) $display("FAIL mis_clear got %0b want 0", out_fault);
      else passed++;
`else
      total++;
      if (req_valid !== 1'b1 || req_addr !== 64'h8000_0002 || out_fault !== 1'b0)
         $display("FAIL mis_pass got %0b/%h/%0b want 1/0000000080000002/0",
                  req_valid, req_addr, out_fault);
      else passed++;
`endif
   endtask

   task automatic test_wrap();
      doReset();
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      fetchOne(32'h0000_0073);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      total++;
      if (req_valid !== 1'b1 || req_addr !== 64'h0)
         $display("FAIL wrap got %0b/%h want 1/0", req_valid, req_addr);
      else passed++;
   endtask

   task automatic test_random();
      logic [63:0] mPc;
      logic [63:0] rpc;
      logic [31:0] memData;
      logic [31:0] rdat;
      logic [31:0] expInst;
      bit mHave, mFault, mOut, mStale, mStart, mis;
      bit memBusy, rv, rdy, ordy, rsp, expReq, expOv;
      doReset();
      mPc     = RST_PC;
      mHave   = 0;
      mFault  = 0;
      mOut    = 0;
      mStale  = 0;
      mStart  = 1;
      memBusy = 0;
      memData = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         rv  = ($urandom_range(0, 9) == 0);
         rpc = RST_PC + 64'($urandom_range(0, 1023)) * 64'd4;
         case ($urandom_range(0, 15))
            0: rpc[1:0] = 2'($urandom_range(1, 3));
            1: rpc = 64'hFFFF_FFFF_FFFF_FFF8;
            default: ;
         endcase
         ordy = ($urandom_range(0, 2) != 0);
         rdy  = 1'($urandom_range(0, 1));
         if (memBusy) begin
            rsp  = 1'($urandom_range(0, 1));
            rdat = memData;
         end else begin
            rsp  = ($urandom_range(0, 15) == 0);
            rdat = $urandom;
         end
         redirect_valid = rv;
         redirect_pc    = rpc;
         out_ready      = ordy;
         req_ready      = rdy;
         resp_valid     = rsp;
         resp_data      = rdat;
         #1;
         mis = 0;
`ifdef IFU_MISALIGN_CHECK_EN
         mis = (mPc[1:0] != 2'b00);
`endif
         expReq  = !mStart && !mOut && !mHave && !mis;
         expOv   = mHave && !rv;
         expInst = mFault ? 32'h0 : memFn(mPc);
         total++;
         if (req_valid !== expReq)
            $display("FAIL rnd_req_valid c%0d got %0b want %0b", cyc, req_valid, expReq);
         else passed++;
         if (expReq) begin
            total++;
            if (req_addr !== mPc)
               $display("FAIL rnd_req_addr c%0d got %h want %h", cyc, req_addr, mPc);
            else passed++;
         end
         total++;
         if (out_valid !== expOv)
            $display("FAIL rnd_out_valid c%0d got %0b want %0b", cyc, out_valid, expOv);
         else passed++;
         if (mHave) begin
            total++;
            if (out_pc !== mPc || out_inst !== expInst)
               $display("FAIL rnd_out c%0d got %h/%h want %h/%h",
                        cyc, out_pc, out_inst, mPc, expInst);
            else passed++;
         end
         total++;
         if (out_fault !== (mHave && mFault))
            $display("FAIL rnd_fault c%0d got %0b want %0b", cyc, out_fault, mHave && mFault);
         else passed++;
         // Memory: one outstanding read, answered any later cycle.
         if (rsp) memBusy = 0;
         if (req_valid && rdy) begin
            memBusy = 1;
            memData = memFn(req_addr);
         end
         // Model: where the fetch stream goes after this edge.
         if (mStart) begin
            mStart = 0;
            if (rv) mPc = rpc;
         end else if (mHave) begin
            if (rv) begin
               mHave  = 0;
               mFault = 0;
               mPc    = rpc;
            end else if (ordy) begin
               mHave  = 0;
               mFault = 0;
               mPc    = mPc + 64'd4;
            end
         end else if (mOut) begin
            if (rsp) begin
               mOut = 0;
               if (!(mStale || rv)) mHave = 1;
               mStale = 0;
            end else if (rv) begin
               mStale = 1;
            end
            if (rv) mPc = rpc;
         end else if (mis) begin
            if (rv) mPc = rpc;
            else begin
               mHave  = 1;
               mFault = 1;
            end
         end else begin
            if (rdy) begin
               mOut   = 1;
               mStale = rv;
            end
            if (rv) mPc = rpc;
         end
         tick();
      end
      zeroIn();
   endtask

   initial begin
      rst = 1'b1;
      zeroIn();
      test_reset();
      test_basic();
      test_req_stall();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_misalign();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
